// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: one micro-step per clock, driving every datapath select and enable.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes halt the FSM and raise a sticky Illegal flag.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       InstrDone,
    output logic       Illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRJ    = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    state_t state_r;
    state_t next_s;
    logic   unused_s;

    // func7 bits other than the sub/add selector carry no meaning for this instruction subset
    assign unused_s = ^{func7[6], func7[4:0]};

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_decode = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  alu_decode = ALU_AND;
            3'b110:  alu_decode = ALU_OR;
            3'b100:  alu_decode = ALU_XOR;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    function automatic logic known_op(input logic [6:0] o);
        case (o)
            OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    endfunction

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state sequencing
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECR;
                    OP_I:         next_s = S_EXECI;
                    OP_BR:        next_s = S_BRANCH;
                    OP_JAL:       next_s = S_JAL;
                    OP_JALR:      next_s = S_JALR;
                    OP_LUI:       next_s = S_LUI;
                    default:      next_s = TRAP_EN ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: next_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_s = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALRJ: next_s = S_ALUWB;
            S_JALR:     next_s = S_JALRJ;
            S_HALT:     next_s = S_HALT;
            default:    next_s = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    // State-decoded controls; BRANCH's PCWrite and the ALU op also look at the instruction fields
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        if (!rst) begin
            case (state_r)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b01;
                    InstrDone = !TRAP_EN && !known_op(op);
                end
                S_MEMADR, S_JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc    = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_decode(func3, func7[5]);
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_decode(func3, 1'b0);
                end
                S_ALUWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_JAL, S_JALRJ: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    InstrDone = 1'b1;
                    case (func3)
                        3'b000: begin ALUControl = ALU_SUB; PCWrite = Zero;  end
                        3'b001: begin ALUControl = ALU_SUB; PCWrite = !Zero; end
                        3'b100: begin ALUControl = ALU_SLT; PCWrite = !Zero; end
                        3'b101: begin ALUControl = ALU_SLT; PCWrite = Zero;  end
                        default: PCWrite = 1'b0;
                    endcase
                end
                S_LUI: begin
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_HALT:  Illegal = TRAP_EN;
                default: Illegal = 1'b0;
            endcase
        end else begin
            PCWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued
// when an instruction is driven and compared one per clock as the FSM steps.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [18:0] got;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;
    exp_t exp_q[$];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, InstrDone, Illegal};

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pcw adr irw mw rw rs sa sb alu imm done ill)",
                     tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] ov(input logic pcw, adr, irw, mw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] alu, imm,
                                       input logic done, ill);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, imm, done, ill};
    endfunction

    task automatic push(input string tag, input logic [18:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // One queued entry per clock, sampled mid low phase
    task automatic drain();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            #1;
            check(e.tag, got, e.v);
            @(negedge clk);
        end
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z);
        op = o; func3 = f3; func7 = f7; Zero = z;
    endtask

    task automatic fetch_decode(input string n, input logic [2:0] imm, input logic done);
        push({n, "_fetch"},  ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0));
        push({n, "_decode"}, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, done, 1'b0));
    endtask

    task automatic push_aluwb(input string n, input logic [2:0] imm);
        push({n, "_aluwb"}, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0));
    endtask

    task automatic do_lw();
        start(7'b0000011, 3'b010, 7'b0000000, 1'b0);
        fetch_decode("lw", 3'b000, 1'b0);
        push("lw_memadr",  ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0));
        push("lw_memread", ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0));
        push("lw_memwb",   ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0));
        drain();
    endtask

    task automatic do_r(input string n, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [2:0] alu);
        start(7'b0110011, f3, f7, 1'b0);
        fetch_decode(n, 3'b000, 1'b0);
        push({n, "_exec"}, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 1'b0, 1'b0));
        push_aluwb(n, 3'b000);
        drain();
    endtask

    task automatic do_i(input string n, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [2:0] alu);
        start(7'b0010011, f3, f7, 1'b0);
        fetch_decode(n, 3'b000, 1'b0);
        push({n, "_exec"}, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 1'b0, 1'b0));
        push_aluwb(n, 3'b000);
        drain();
    endtask

    task automatic do_br(input string n, input logic [2:0] f3, input logic z,
                         input logic [2:0] alu, input logic pcw);
        start(7'b1100011, f3, 7'b0000000, z);
        fetch_decode(n, 3'b010, 1'b0);
        push({n, "_branch"}, ov(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 3'b010, 1'b1, 1'b0));
        drain();
    endtask

    task automatic do_lui();
        start(7'b0110111, 3'b000, 7'b0000000, 1'b0);
        fetch_decode("lui", 3'b100, 1'b0);
        push("lui_wb", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b1, 1'b0));
        drain();
    endtask

    initial begin
        rst = 1'b1;
        start(7'b0000000, 3'b000, 7'b0000000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_defaults", got, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        // lw interrupted by reset while in MEMADR
        start(7'b0000011, 3'b010, 7'b0000000, 1'b0);
        fetch_decode("lw_abort", 3'b000, 1'b0);
        drain();
        #1;
        check("pre_rst_memadr", got, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_memadr", got, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_lw();

        start(7'b0100011, 3'b010, 7'b0000000, 1'b0);
        fetch_decode("sw", 3'b001, 1'b0);
        push("sw_memadr", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0, 1'b0));
        push("sw_memwr",  ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b1, 1'b0));
        drain();

        do_r("r_sub",  3'b000, 7'b0100000, 3'b001);
        do_r("r_add",  3'b000, 7'b0000000, 3'b000);
        do_r("r_and",  3'b111, 7'b0000000, 3'b010);
        do_r("r_or",   3'b110, 7'b0000000, 3'b011);
        do_r("r_sltu", 3'b011, 7'b0000000, 3'b110);
        do_r("r_slt",  3'b010, 7'b0000000, 3'b100);
        do_r("r_sll",  3'b001, 7'b0000000, 3'b000);
        do_i("addi_f7", 3'b000, 7'b0100000, 3'b000);
        do_i("xori",    3'b100, 7'b0000000, 3'b101);

        do_br("beq_z1", 3'b000, 1'b1, 3'b001, 1'b1);
        do_br("beq_z0", 3'b000, 1'b0, 3'b001, 1'b0);
        do_br("bne_z1", 3'b001, 1'b1, 3'b001, 1'b0);
        do_br("blt_z0", 3'b100, 1'b0, 3'b100, 1'b1);
        do_br("bge_z0", 3'b101, 1'b0, 3'b100, 1'b0);
        do_br("bge_z1", 3'b101, 1'b1, 3'b100, 1'b1);
        do_br("bfn3_z1", 3'b010, 1'b1, 3'b000, 1'b0);

        start(7'b1101111, 3'b000, 7'b0000000, 1'b0);
        fetch_decode("jal", 3'b011, 1'b0);
        push("jal_jump", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 1'b0, 1'b0));
        push_aluwb("jal", 3'b011);
        drain();

        start(7'b1100111, 3'b000, 7'b0000000, 1'b0);
        fetch_decode("jalr", 3'b000, 1'b0);
        push("jalr_adr",  ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0));
        push("jalr_jump", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0));
        push_aluwb("jalr", 3'b000);
        drain();

        do_lui();

        start(7'b1111111, 3'b000, 7'b0000000, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        fetch_decode("illegal", 3'b000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push("illegal_halt", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1));
        end
        drain();
`else
        fetch_decode("illegal_nop", 3'b000, 1'b1);
        drain();
        do_lui();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I datapath variant.
- Consumes the decode fields (op, func3, func7) and the ALU Zero flag that the datapath exports.
- Drives every datapath mux select, write enable and ALU operation, one micro-step per clock.
- Replaces the combinational single-cycle decoder.
- Supported instructions: lw, sw, R-type ALU ops, I-type ALU ops, beq/bne/blt/bge, jal, jalr, lui.

Parameters:
- RESET_STATE, 4'd0, encoding of FETCH loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op  input  7  Instr[6:0] from instruction register.
- func3  input  3  Instr[14:12].
- func7  input  7  Instr[31:25].
- Zero  input  1  ALU result == 0.
- PCWrite  output  1  PC register load enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  output  1  instruction register and OldPC load enable.
- MemWrite  output  1  data store enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00=ALUOut, 01=MemData, 10=ALUResult, 11=ImmExt.
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RegA.
- ALUSrcB  output  2  00=RegB, 01=ImmExt, 10=constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- InstrDone  output  1  one-cycle pulse in the last state of each instruction.
- Illegal  output  1  sticky illegal-opcode flag; see Optional Feature.

Behaviour:
- State register updates on posedge clk. rst asynchronously forces FETCH.
- Reset mid-instruction abandons the instruction immediately; no enable stays asserted.
- All outputs are Moore (state-decoded), except:
  - PCWrite in BRANCH, which depends on Zero;
  - ALUControl and ImmSrc, which also decode op/func3/func7.
- Output defaults: all enables 0, selects 00, ALUControl add. Only the deltas per state are listed below.
- ImmSrc is always driven from op: lw/jalr/I-type→I, sw→S, branch→B, jal→J, lui→U, else I.

States:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1 (PC←PC+4). Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut←OldPC+imm). Next state by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - other → ILLEGAL handling
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, InstrDone=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. Next: ALUWB. ALUControl from func3:
  - 000: func7[5] ? sub : add
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu
  - unsupported func3 → add
- EXECI: ALUSrcA=10, ALUSrcB=01. Next: ALUWB. ALUControl from func3 as in EXECR, except func7 is ignored (addi never subtracts).
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC←target, ALUOut←OldPC+4). Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, add (ALUOut←rs1+imm). Next: JALRJ.
- JALRJ: same outputs as JAL. Next: ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, InstrDone=1. Next: FETCH.
  - beq: sub, PCWrite=Zero.
  - bne: sub, PCWrite=!Zero.
  - blt: slt, PCWrite=!Zero.
  - bge: slt, PCWrite=Zero.
  - other func3: PCWrite=0.
- LUI: ResultSrc=11, RegWrite=1, InstrDone=1. Next: FETCH.

Latency (cycles, FETCH included):
- lw 5, jalr 5
- sw 4, R-type 4, I-type 4, jal 4
- branch 3, lui 3

Other rules:
- Exactly one InstrDone pulse per retired instruction.
- MemWrite and RegWrite are never asserted in the same cycle.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE enters HALT.
  - In HALT, all enables are 0 and Illegal=1; the FSM stays there until rst.
  - InstrDone is not pulsed for the illegal instruction.
- Undefined:
  - An unknown op in DECODE acts as a NOP: InstrDone=1 in DECODE, next state FETCH (2 cycles).
  - Illegal is tied 0.

Test Plan:
- rst high mid-MEMADR → outputs immediately at defaults (all enables 0, selects 00, ALUControl add); first cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op=0000011) → IRWrite, then DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1, InstrDone=1) on cycles 1..5.
- R-type sub (op=0110011, func3=000, func7=0100000) → ALUControl=001 in EXECR; RegWrite on cycle 4.
- beq with Zero=1 → PCWrite=1 in cycle 3. bne with Zero=1 → PCWrite=0. blt with Zero=0 → ALUControl=100, PCWrite=1.
- jalr (op=1100111) → cycles FETCH, DECODE, JALR, JALRJ (PCWrite=1, ALUSrcA=01, ALUSrcB=10), ALUWB (RegWrite=1).
- op=1111111 → with CTRL_ILLEGAL_TRAP_EN: Illegal=1 and no further IRWrite for 10 cycles. Without it: InstrDone in cycle 2, FETCH in cycle 3.
